// File: rtl/bnn_pkg.sv
// Shared definitions for the binary classifier layers: pooled-map geometry,
// controller states and a generic popcount helper.
package bnn_pkg;

    localparam int POOL_ROWS = 4;
    localparam int POOL_COLS = 4;
    localparam int POOL_BITS = POOL_ROWS * POOL_COLS;

    // Widest vector the shared popcount handles; narrower callers zero-extend.
    localparam int POP_MAX_W = 256;
    localparam int POP_CNT_W = $clog2(POP_MAX_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bnn_state_e;

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [POP_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + POP_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Parameterized-width combinational popcount shared by the binary layers.
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    logic [POP_MAX_W-1:0] data_ext;

    assign data_ext = POP_MAX_W'(data);
    assign count    = CNT_W'(popcount(data_ext));

endmodule

// File: rtl/bnn_fc_argmax.sv
// Binary fully-connected layer with argmax: one XNOR-popcount neuron per cycle
// against locally stored weight rows, reporting the best index and score.
//
// state | meaning
// IDLE  | ready for a frame; weight writes allowed
// RUN   | scoring neurons serially; weight writes ignored
// DONE  | result held on o_valid until downstream accepts
module bnn_fc_argmax
    import bnn_pkg::*;
#(
    parameter  int NCH     = 2,
    parameter  int NOUT    = 10,
    localparam int IN_W    = NCH * POOL_BITS,
    localparam int SCORE_W = $clog2(IN_W + 1),
    localparam int IDX_W   = $clog2(NOUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [0:IN_W-1]    i_fmap,
    input  logic               i_wgt_we,
    input  logic [IDX_W-1:0]   i_wgt_addr,
    input  logic [0:IN_W-1]    i_wgt_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [IDX_W-1:0]   o_class,
    output logic [SCORE_W-1:0] o_score
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOUT - 1);

    bnn_state_e state, state_nx;

    // Bit order is irrelevant to XNOR-popcount as long as map and rows agree.
    logic [IN_W-1:0]    fmap_q;
    logic [IN_W-1:0]    wgt [NOUT];
    logic [IN_W-1:0]    xnor_row;
    logic [SCORE_W-1:0] score_c;

    logic [IDX_W-1:0]   cnt;
    logic               issue_done;
    logic               pend_q;
    logic [SCORE_W-1:0] score_q;
    logic [IDX_W-1:0]   sidx_q;
    logic [SCORE_W-1:0] best_score;
    logic [IDX_W-1:0]   best_idx;
    logic               wgt_we_ok;

    assign xnor_row  = ~(fmap_q ^ wgt[cnt]);
    assign wgt_we_ok = i_wgt_we && (state != RUN)
                       && ({1'b0, i_wgt_addr} < (IDX_W + 1)'(NOUT));

    bnn_popcount #(
        .WIDTH (IN_W),
        .CNT_W (SCORE_W)
    ) u_popcount (
        .data  (xnor_row),
        .count (score_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        case (state)
            IDLE: begin
                o_ready = rst_n;
                if (i_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (pend_q && (sidx_q == LAST_IDX)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Two-stage scoring: the popcount of row cnt is registered, then compared
    // against the running best one edge later, keeping the adder tree and the
    // comparator in separate cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fmap_q     <= '0;
            cnt        <= '0;
            issue_done <= 1'b0;
            pend_q     <= 1'b0;
            score_q    <= '0;
            sidx_q     <= '0;
            best_score <= '0;
            best_idx   <= '0;
            for (int i = 0; i < NOUT; i++) begin
                wgt[i] <= '0;
            end
        end else begin
            if (wgt_we_ok) begin
                wgt[i_wgt_addr] <= i_wgt_data;
            end
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        fmap_q     <= i_fmap;
                        cnt        <= '0;
                        issue_done <= 1'b0;
                        pend_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!issue_done) begin
                        score_q <= score_c;
                        sidx_q  <= cnt;
                        pend_q  <= 1'b1;
                        if (cnt == LAST_IDX) begin
                            issue_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        pend_q <= 1'b0;
                    end
                    // Strict compare keeps the lowest index on ties.
                    if (pend_q && ((sidx_q == '0) || (score_q > best_score))) begin
                        best_score <= score_q;
                        best_idx   <= sidx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_class = best_idx;
    assign o_score = best_score;

endmodule
